// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants and FSM state encoding for the conv MAC / requantizer path
package cnn_pkg;
  localparam int ACC_W   = 64;
  localparam int INT8_W  = 8;
  localparam int UINT8_W = 8;
  localparam int PROD_W  = 18;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/zp_mult.sv
// zp_mult: zero-point removal plus 9x9 signed multiply with a registered product
//   clk, rst(active-low async) | en_i: capture a product | x_i/w_i: activation/weight
//   xz_i/wz_i: zero-points | prod_o: registered dx*dw | prod_v_o: prod_o is fresh this cycle
module zp_mult
  import cnn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic [UINT8_W-1:0]       x_i,
  input  logic [INT8_W-1:0]        w_i,
  input  logic [UINT8_W-1:0]       xz_i,
  input  logic [INT8_W-1:0]        wz_i,
  output logic signed [PROD_W-1:0] prod_o,
  output logic                     prod_v_o
);
  logic signed [8:0]        dx, dw;
  logic signed [PROD_W-1:0] prod_d, prod_q;
  logic                     prod_v_q;
  assign dx     = $signed({1'b0, x_i} - {1'b0, xz_i});
  assign dw     = $signed({w_i[7], w_i} - {wz_i[7], wz_i});
  assign prod_d = dx * dw;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      prod_q   <= '0;
      prod_v_q <= 1'b0;
    end else begin
      prod_v_q <= en_i;
      if (en_i) prod_q <= prod_d;
    end
  assign prod_o   = prod_q;
  assign prod_v_o = prod_v_q;
endmodule

// File: rtl/conv_mac_accumulator.sv
// conv_mac_accumulator: accumulates one kernel window of zero-point-corrected products onto a bias
//   clk, rst(active-low async) | start, bias, x_zero, w_zero: open a window (IDLE only)
//   in_valid/in_ready, x_in, w_in: tap stream | acc_out/out_valid/out_ready: held result
//   busy: any state other than IDLE
module conv_mac_accumulator
  import cnn_pkg::*;
#(
  parameter int N_TAPS = 9,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        bias,
  input  logic [UINT8_W-1:0] x_zero,
  input  logic [INT8_W-1:0]  w_zero,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [UINT8_W-1:0] x_in,
  input  logic [INT8_W-1:0]  w_in,
  output logic [ACC_W-1:0]   acc_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);
  state_e                   state_d, state_q;
  logic [CNT_W-1:0]         cnt_d, cnt_q;
  logic [ACC_W-1:0]         acc_d, acc_q, out_d, out_q;
  logic [UINT8_W-1:0]       xz_d, xz_q;
  logic [INT8_W-1:0]        wz_d, wz_q;
  logic signed [PROD_W-1:0] prod;
  logic                     prod_v, beat;
  assign in_ready  = state_q == ACCUM;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign acc_out   = out_q;
  assign beat      = in_valid & in_ready;
  zp_mult u_zp_mult (
    .clk      (clk),
    .rst      (rst),
    .en_i     (beat),
    .x_i      (x_in),
    .w_i      (w_in),
    .xz_i     (xz_q),
    .wz_i     (wz_q),
    .prod_o   (prod),
    .prod_v_o (prod_v)
  );
  // Stage 2 adds whatever product stage 1 registered last cycle; in DRAIN this is the final tap,
  // so the hold register captures the completed sum on the way into DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xz_d    = xz_q;
    wz_d    = wz_q;
    out_d   = out_q;
    acc_d   = prod_v ? acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod} : acc_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = ACCUM;
        acc_d   = {{(ACC_W-32){bias[31]}}, bias};
        cnt_d   = '0;
        xz_d    = x_zero;
        wz_d    = w_zero;
      end
      ACCUM: if (beat) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N_TAPS - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = DONE;
        out_d   = acc_d;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      xz_q    <= '0;
      wz_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      xz_q    <= xz_d;
      wz_q    <= wz_d;
    end
endmodule

// File: tb/tb_conv_mac_accumulator.sv
// tb_conv_mac_accumulator: directed self-checking bench for conv_mac_accumulator
module tb_conv_mac_accumulator;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] bias = '0;
  logic [7:0]  x_zero = '0, w_zero = '0, x_in = '0, w_in = '0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, busy;
  logic [63:0] acc_out, held;
  int          checks = 0, errors = 0;
  logic [7:0]  xs [9];
  logic [7:0]  ws [9];
  conv_mac_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bias      (bias),
    .x_zero    (x_zero),
    .w_zero    (w_zero),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .w_in      (w_in),
    .acc_out   (acc_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic do_start(input logic [31:0] b, input logic [7:0] xz, input logic [7:0] wz);
    start = 1'b1;
    bias = b;
    x_zero = xz;
    w_zero = wz;
    tick();
    start = 1'b0;
    bias = 32'hdead_beef;
    x_zero = 8'h55;
    w_zero = 8'haa;
    chk("acc_rdy", {63'd0, in_ready}, 64'd1);
  endtask
  task automatic feed(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b0;
        x_in = 8'($urandom);
        w_in = 8'($urandom);
        start = 1'b1;
        tick();
      end
      start = 1'b0;
      in_valid = 1'b1;
      x_in = xs[i];
      w_in = ws[i];
      if (gaps) chk("beat_rdy", {63'd0, in_ready}, 64'd1);
      tick();
    end
    in_valid = 1'b0;
  endtask
  task automatic result(input string tag, input logic [63:0] exp);
    chk({tag, "_drain_ov"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_drain_rdy"}, {63'd0, in_ready}, 64'd0);
    tick();
    chk({tag, "_lat_ov"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_acc"}, acc_out, exp);
  endtask
  task automatic consume;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("consume_ov", {63'd0, out_valid}, 64'd0);
    chk("consume_busy", {63'd0, busy}, 64'd0);
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_rdy", {63'd0, in_ready}, 64'd0);
    chk("rst_ov", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_acc", acc_out, 64'd0);
    rst = 1'b1;
    tick();
    // basic: 100 + (1+..+9)
    for (int i = 0; i < 9; i++) begin
      xs[i] = 8'(i + 1);
      ws[i] = 8'd1;
    end
    do_start(32'd100, 8'd0, 8'd0);
    chk("busy", {63'd0, busy}, 64'd1);
    feed(9, 1'b0);
    result("basic", 64'd145);
    consume();
    // reset mid-window after 4 beats
    do_start(32'd5, 8'd0, 8'd0);
    feed(4, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_rdy", {63'd0, in_ready}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_acc", acc_out, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_ov", {63'd0, out_valid}, 64'd0);
    // zero-points: 9 * (0-128) * (-128+3)
    for (int i = 0; i < 9; i++) begin
      xs[i] = 8'd0;
      ws[i] = 8'h80;
    end
    do_start(32'd0, 8'd128, 8'hfd);
    feed(9, 1'b0);
    result("zp", 64'd144000);
    consume();
    // signed extremes: -2^31 + 9*(255*-128)
    for (int i = 0; i < 9; i++) begin
      xs[i] = 8'd255;
      ws[i] = 8'h80;
    end
    do_start(32'h8000_0000, 8'd0, 8'd0);
    feed(9, 1'b0);
    result("ext", -64'sd2147777408);
    consume();
    // handshake: gaps, then hold with out_ready low while poking start/in_valid
    for (int i = 0; i < 9; i++) begin
      xs[i] = 8'd2;
      ws[i] = 8'd3;
    end
    do_start(-32'sd10, 8'd0, 8'd0);
    feed(9, 1'b1);
    result("hs", 64'd44);
    held = acc_out;
    start = 1'b1;
    in_valid = 1'b1;
    bias = 32'd7;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i % 4 == 0) begin
        chk("hold_acc", acc_out, 64'd44);
        chk("hold_ov", {63'd0, out_valid}, 64'd1);
        chk("hold_rdy", {63'd0, in_ready}, 64'd0);
      end
    end
    in_valid = 1'b0;
    // back-to-back: start alongside out_ready is ignored
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    chk("b2b_ov", {63'd0, out_valid}, 64'd0);
    chk("b2b_busy", {63'd0, busy}, 64'd0);
    chk("b2b_acc_kept", acc_out, held);
    for (int i = 0; i < 9; i++) begin
      xs[i] = 8'(i + 1);
      ws[i] = 8'hff;
    end
    do_start(32'd0, 8'd0, 8'd0);
    feed(9, 1'b1);
    result("b2b", -64'sd45);
    consume();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
